// File: rtl/riscv_v_bypass_history.sv
// Vector write-history bypass: forwards per-byte data from the youngest matching in-flight RF write.
// Latency: zero-cycle combinational forwarding from registered history; a write is visible the cycle after capture.
// Backpressure: none; history shifts only on advance, holds otherwise, and flush drops every entry.
module riscv_v_bypass_history #(
    parameter int DATA_WIDTH   = 128,
    parameter int NUM_BYTES    = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int DEPTH        = 4,
    parameter int NUM_RD_PORTS = 3,
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               advance,
    input  logic                               flush,
    input  logic                               wr_valid,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [NUM_BYTES-1:0]               wr_be,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_in,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_out,
    output logic [NUM_RD_PORTS*NUM_BYTES-1:0]  rd_hit_be,
    output logic [CNT_WIDTH-1:0]               occupancy
);

    // One in-flight RF write; entry 0 is the youngest.
    typedef struct packed {
        logic                  vld;
        logic [ADDR_WIDTH-1:0] addr;
        logic [NUM_BYTES-1:0]  be;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    entry_t                 hist [DEPTH];
    entry_t                 head_ent;
    logic [CNT_WIDTH-1:0]   occ_q;
    logic [CNT_WIDTH-1:0]   occ_inc;
    logic [CNT_WIDTH-1:0]   occ_dec;

    // Per-port, per-entry address/valid match, shared by all byte lanes of the port.
    logic [DEPTH-1:0]       addr_match [NUM_RD_PORTS];

    // Pack the pipeline-head write into an entry; a bubble still shifts in with vld=0.
    always_comb begin
        head_ent.vld  = wr_valid;
        head_ent.addr = wr_addr;
        head_ent.be   = wr_be;
        head_ent.dat  = wr_data;
    end

    // History shift register: reset clears everything, flush kills valids, advance shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist[i].vld <= 1'b0;
            end
        end else if (advance) begin
            hist[0] <= head_ent;
            for (int i = 1; i < DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    // Occupancy delta for a shifting edge: one in from the head, one out from the tail.
    always_comb begin
        occ_inc = CNT_WIDTH'(wr_valid);
        occ_dec = CNT_WIDTH'(hist[DEPTH-1].vld);
    end

    // Registered valid-entry count; a simultaneous insert and retire cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (advance) begin
            occ_q <= occ_q + occ_inc - occ_dec;
        end
    end

    assign occupancy = occ_q;

    // Address match per port against every valid entry.
    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            addr_match[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_match[p][i] = hist[i].vld &&
                                   (hist[i].addr == rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]);
            end
        end
    end

    // Per-byte merge: scan oldest to youngest so the youngest enabled match wins; else RF data.
    always_comb begin
        rd_data_out = rd_data_in;
        rd_hit_be   = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (addr_match[p][i] && hist[i].be[b]) begin
                        rd_data_out[(p*NUM_BYTES + b)*8 +: 8] = hist[i].dat[b*8 +: 8];
                        rd_hit_be[p*NUM_BYTES + b]            = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_v_bypass_history.sv
// Bench for riscv_v_bypass_history: directed scenarios plus randomized traffic against a queue model.
// Latency: outputs compared on every falling edge against the model state after the last rising edge.
// Backpressure: stimulus never presents wr_valid without advance.
module tb_riscv_v_bypass_history;

    localparam int DW  = 128;
    localparam int NB  = DW / 8;
    localparam int AW  = 5;
    localparam int DEP = 4;
    localparam int NP  = 3;
    localparam int CW  = $clog2(DEP + 1);
    localparam int WW  = NP * DW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              advance = 1'b0;
    logic              flush = 1'b0;
    logic              wr_valid = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [NB-1:0]     wr_be = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [NP*AW-1:0]  rd_addr = '0;
    logic [NP*DW-1:0]  rd_data_in = '0;
    logic [NP*DW-1:0]  rd_data_out;
    logic [NP*NB-1:0]  rd_hit_be;
    logic [CW-1:0]     occupancy;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit chk_en   = 1'b0;

    riscv_v_bypass_history #(
        .DATA_WIDTH(DW), .NUM_BYTES(NB), .ADDR_WIDTH(AW),
        .DEPTH(DEP), .NUM_RD_PORTS(NP), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .advance(advance), .flush(flush),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data_in(rd_data_in),
        .rd_data_out(rd_data_out), .rd_hit_be(rd_hit_be), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Model: a list of in-flight writes, youngest first, always DEP long (bubbles included).
    typedef struct {
        bit            vld;
        logic [AW-1:0] addr;
        logic [NB-1:0] be;
        logic [DW-1:0] dat;
    } ment_t;

    ment_t mq[$];

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        ment_t e;
        e.vld = 0; e.addr = '0; e.be = '0; e.dat = '0;
        mq.delete();
        for (int i = 0; i < DEP; i++) mq.push_back(e);
    endtask

    // Apply the edge rules to the model using the inputs present at this rising edge.
    task automatic model_step();
        ment_t e;
        if (rst) begin
            model_reset();
        end else if (flush) begin
            foreach (mq[i]) mq[i].vld = 0;
        end else if (advance) begin
            e.vld = wr_valid; e.addr = wr_addr; e.be = wr_be; e.dat = wr_data;
            mq.push_front(e);
            void'(mq.pop_back());
        end
    endtask

    // Expected outputs: per port and byte, the first (youngest) valid enabled match, else RF data.
    task automatic model_outputs(output logic [NP*DW-1:0] eo, output logic [NP*NB-1:0] eh,
                                 output logic [CW-1:0] eocc);
        int n;
        bit found;
        eo = rd_data_in;
        eh = '0;
        n  = 0;
        foreach (mq[i]) if (mq[i].vld) n++;
        eocc = CW'(n);
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < NB; b++) begin
                found = 0;
                for (int i = 0; i < DEP; i++) begin
                    if (!found && mq[i].vld && mq[i].addr == rd_addr[p*AW +: AW] && mq[i].be[b]) begin
                        found = 1;
                        eo[(p*NB + b)*8 +: 8] = mq[i].dat[b*8 +: 8];
                        eh[p*NB + b] = 1'b1;
                    end
                end
            end
        end
    endtask

    // Single compare process: every falling edge once the model is aligned with the DUT.
    always @(negedge clk) begin
        logic [NP*DW-1:0] eo;
        logic [NP*NB-1:0] eh;
        logic [CW-1:0]    eocc;
        if (chk_en) begin
            model_outputs(eo, eh, eocc);
            check("model_data", WW'(rd_data_out), WW'(eo));
            check("model_hit",  WW'(rd_hit_be),   WW'(eh));
            check("model_occ",  WW'(occupancy),   WW'(eocc));
        end
    end

    function automatic logic [DW-1:0] rand_dw();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NP*DW-1:0] rand_in();
        return {rand_dw(), rand_dw(), rand_dw()};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_wr(input logic adv, input logic v, input logic [AW-1:0] a,
                          input logic [NB-1:0] be, input logic [DW-1:0] d);
        advance = adv; wr_valid = v; wr_addr = a; wr_be = be; wr_data = d;
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        logic [DW-1:0] bytev;
        model_reset();

        // Reset held two cycles with random RF data.
        rst = 1'b1;
        rd_data_in = rand_in();
        tick();
        chk_en = 1'b1;
        tick();
        #1;
        check("rst_occ",  WW'(occupancy),   WW'(0));
        check("rst_hit",  WW'(rd_hit_be),   WW'(0));
        check("rst_data", WW'(rd_data_out), WW'(rd_data_in));
        rst = 1'b0;

        // Single full-width write to v3, then read it back on port 0.
        set_wr(1, 1, 5'd3, 16'hFFFF, {16{8'hA5}});
        tick();
        set_wr(0, 0, 5'd0, 16'h0, '0);
        rd_addr = {5'd0, 5'd0, 5'd3};
        rd_data_in = rand_in();
        #1;
        check("wr3_data", WW'(rd_data_out[DW-1:0]), WW'({16{8'hA5}}));
        check("wr3_hit",  WW'(rd_hit_be[NB-1:0]),   WW'(16'hFFFF));
        check("wr3_occ",  WW'(occupancy),           WW'(1));

        // Two partial writes to v5 merged with RF bytes on port 1.
        set_wr(1, 1, 5'd5, 16'h00FF, {16{8'h11}});
        tick();
        set_wr(1, 1, 5'd5, 16'h0F0F, {16{8'h22}});
        tick();
        set_wr(0, 0, 5'd0, 16'h0, '0);
        rd_addr = {5'd0, 5'd5, 5'd0};
        rd_data_in = {rand_dw(), {16{8'hCC}}, rand_dw()};
        #1;
        check("merge_data", WW'(rd_data_out[DW +: DW]), WW'(128'hCCCCCCCC_22222222_11111111_22222222));
        check("merge_hit",  WW'(rd_hit_be[NB +: NB]),   WW'(16'h0FFF));

        // Write to v7 then four bubbles: visible for four cycles, gone on the fifth edge.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_wr(1, 1, 5'd7, 16'hFFFF, {16{8'h77}});
        tick();
        for (int j = 0; j < 5; j++) begin
            rd_addr = {5'd0, 5'd0, 5'd7};
            rd_data_in = rand_in();
            #1;
            check("age_hit", WW'(rd_hit_be[NB-1:0]), WW'((j < 4) ? 16'hFFFF : 16'h0));
            check("age_occ", WW'(occupancy),         WW'((j < 4) ? 1 : 0));
            set_wr(1, 0, 5'd0, 16'h0, '0);
            if (j < 4) tick();
        end

        // Fill four writes, hold three cycles, then flush against a concurrent write.
        for (int k = 0; k < 4; k++) begin
            set_wr(1, 1, AW'(8 + k), 16'hFFFF, {16{8'(8 + k)}});
            tick();
        end
        set_wr(0, 0, 5'd0, 16'h0, '0);
        for (int k = 0; k < 3; k++) tick();
        rd_addr = {5'd11, 5'd9, 5'd8};
        #1;
        check("hold_occ",  WW'(occupancy),                  WW'(4));
        check("hold_data", WW'(rd_data_out[DW-1:0]),        WW'({16{8'h08}}));
        set_wr(1, 1, 5'd12, 16'hFFFF, {16{8'h0C}});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_wr(0, 0, 5'd0, 16'h0, '0);
        rd_addr = {5'd12, 5'd9, 5'd8};
        #1;
        check("flush_occ", WW'(occupancy), WW'(0));
        check("flush_hit", WW'(rd_hit_be), WW'(0));

        // Continuous writes to v13: occupancy saturates at DEPTH; all ports agree.
        for (int k = 0; k < 6; k++) begin
            set_wr(1, 1, 5'd13, 16'hFFFF, {16{8'(k + 1)}});
            tick();
            rd_addr = {5'd13, 5'd13, 5'd13};
            rd_data_in = rand_in();
            #1;
            bytev = {16{8'(k + 1)}};
            exp_d = bytev;
            check("full_occ",  WW'(occupancy),   WW'((k + 1 < 4) ? k + 1 : 4));
            check("full_data", WW'(rd_data_out), WW'({exp_d, exp_d, exp_d}));
        end
        set_wr(0, 0, 5'd0, 16'h0, '0);

        // Randomized traffic: small address space and sparse byte enables to exercise merging.
        for (int n = 0; n < 3000; n++) begin
            logic adv;
            adv      = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 399) == 0);
            flush    = ($urandom_range(0, 29) == 0);
            advance  = adv;
            wr_valid = adv && ($urandom_range(0, 4) != 0);
            wr_addr  = AW'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       wr_be = 16'hFFFF;
                1:       wr_be = 16'h0;
                default: wr_be = NB'($urandom);
            endcase
            wr_data = rand_dw();
            if ($urandom_range(0, 4) == 0) begin
                logic [AW-1:0] a;
                a = AW'($urandom_range(0, 3));
                rd_addr = {a, a, a};
            end else begin
                rd_addr = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
            end
            rd_data_in = rand_in();
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
